// File: rtl/pause_sequencer_pkg.sv
// rtl/pause_sequencer_pkg.sv - shared types and option bit positions for the pause sequencer
package pause_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ENTER  = 2'd1,
    PAUSED = 2'd2,
    EXIT   = 2'd3
  } pause_state_t;

  localparam int OPT_PAUSE_OSD = 0;
  localparam int OPT_DIM       = 1;

endpackage

// File: rtl/pause_sequencer_if.sv
// rtl/pause_sequencer_if.sv - video timing, pause sources and pause/grant outputs bundle
interface pause_sequencer_if #(
  parameter int NREQ = 2
);
  logic            vblank;
  logic            user_button;
  logic            osd_status;
  logic [1:0]      options;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            pause_cpu;
  logic            paused_stable;
  logic            dim_video;

  // Stimulus/core side: drives sources, observes pause state.
  modport master (
    output vblank, user_button, osd_status, options, req,
    input  gnt, pause_cpu, paused_stable, dim_video
  );

  // Sequencer side.
  modport slave (
    input  vblank, user_button, osd_status, options, req,
    output gnt, pause_cpu, paused_stable, dim_video
  );
endinterface

// File: rtl/pause_req_arbiter.sv
// rtl/pause_req_arbiter.sv - fixed-priority, non-preemptive ownership grant for pause requesters
module pause_req_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  logic [NREQ-1:0] pick;

  // Lowest-index asserted request is the candidate owner.
  always_comb begin
    pick = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  // Hold the owner until its request drops; an idle cycle always separates owners.
  always_ff @(posedge clk_sys) begin
    if (reset || !enable) begin
      gnt <= '0;
    end else if (gnt != '0) begin
      if ((gnt & req) == '0) begin
        gnt <= '0;
      end
    end else begin
      gnt <= pick;
    end
  end

endmodule

// File: rtl/pause_sequencer.sv
// rtl/pause_sequencer.sv - vblank-aligned pause FSM with requester grants and burn-in dim timer
module pause_sequencer
  import pause_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter int          CLKSPD    = 12,
  parameter logic [31:0] DIM_TICKS = 32'(CLKSPD * 10000000)
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  pause_sequencer_if.slave        bus
);

  pause_state_t state;
  pause_state_t state_next;
  logic         vblank_q;
  logic         btn_q;
  logic         toggle;
  logic         demand;
  logic         vb_rise;
  logic [31:0]  dim_cnt;
  logic [31:0]  dim_cnt_next;

  assign demand  = (|bus.req) | toggle | (bus.osd_status & bus.options[OPT_PAUSE_OSD]);
  assign vb_rise = bus.vblank & ~vblank_q;

  // Edge history for vblank and the button; button edge flips the user toggle.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      vblank_q <= 1'b0;
      btn_q    <= bus.user_button;
      toggle   <= 1'b0;
    end else begin
      vblank_q <= bus.vblank;
      btn_q    <= bus.user_button;
      if (bus.user_button && !btn_q) begin
        toggle <= ~toggle;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Transitions into and out of pause only on a vblank rising edge.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:    if (demand) state_next = ENTER;
      ENTER:  if (!demand) state_next = RUN;
              else if (vb_rise) state_next = PAUSED;
      PAUSED: if (!demand) state_next = EXIT;
      EXIT:   if (demand) state_next = PAUSED;
              else if (vb_rise) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Pause outputs decode straight from the state register.
  always_comb begin
    bus.pause_cpu     = (state == PAUSED) || (state == EXIT);
    bus.paused_stable = (state == PAUSED);
  end

  // Dim counter: counts while paused, holds in EXIT, clears otherwise or when disabled.
  always_comb begin
    dim_cnt_next = dim_cnt;
    if (!bus.options[OPT_DIM] || state == RUN || state == ENTER) begin
      dim_cnt_next = '0;
    end else if (state == PAUSED && dim_cnt != DIM_TICKS) begin
      dim_cnt_next = dim_cnt + 32'd1;
    end
  end

  // Counter and registered dim flag, flag tracks the value being loaded.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dim_cnt       <= '0;
      bus.dim_video <= 1'b0;
    end else begin
      dim_cnt       <= dim_cnt_next;
      bus.dim_video <= (dim_cnt_next == DIM_TICKS);
    end
  end

  pause_req_arbiter #(
    .NREQ(NREQ)
  ) u_arbiter (
    .clk_sys (clk_sys),
    .reset   (reset),
    .enable  (state == PAUSED),
    .req     (bus.req),
    .gnt     (bus.gnt)
  );

endmodule
